// File: rtl/ballot_pkg.sv
// Shared types and constants for the ballot controller and its timers.
package ballot_pkg;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_ARMED_ENC   = 3'd1;
  localparam logic [2:0] ST_COMMIT_ENC  = 3'd2;
  localparam logic [2:0] ST_LOCKOUT_ENC = 3'd3;
  localparam logic [2:0] ST_COUNT_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_ARMED   = ST_ARMED_ENC,
    ST_COMMIT  = ST_COMMIT_ENC,
    ST_LOCKOUT = ST_LOCKOUT_ENC,
    ST_COUNT   = ST_COUNT_ENC
  } state_t;

  localparam int                   SPOIL_W   = 8;
  localparam logic [SPOIL_W-1:0]   SPOIL_SAT = SPOIL_W'(255);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/ballot_timer.sv
// Loadable down-counter; expired is high during the last cycle of a loaded
// interval, so a load of N gives exactly N cycles before expiry is acted on.
module ballot_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == W'(1));

endmodule

// File: rtl/ballot_controller.sv
// Voting-flow sequencer: arms one ballot per officer enable, commits a single
// one-hot vote, enforces lockout, times out idle ballots, and cycles the display.
module ballot_controller
  import ballot_pkg::*;
#(
  parameter int N_CAND         = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int ACK_CYCLES     = 16,
  parameter int DISP_CYCLES    = 100
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        enable_ballot,
  input  logic [N_CAND-1:0]           press,
  output logic [N_CAND-1:0]           vote_valid,
  output logic                        ready,
  output logic                        ack,
  output logic                        timeout,
  output logic [SPOIL_W-1:0]          spoiled_cnt,
  output logic [$clog2(N_CAND)-1:0]   disp_sel
);

  localparam int DW = $clog2(N_CAND);
  localparam int TW = $clog2(max3(TIMEOUT_CYCLES, ACK_CYCLES, DISP_CYCLES) + 1);

  state_t              state_q, state_d;
  logic [N_CAND-1:0]   vote_valid_q, vote_valid_d;
  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic                timeout_q, timeout_d;
  logic [SPOIL_W-1:0]  spoiled_q, spoiled_d;
  logic [DW-1:0]       disp_sel_q, disp_sel_d;

  logic spoil_inc;
  logic any_press;
  logic single_press;
  logic arm_load, arm_exp;
  logic lock_load, lock_exp;
  logic disp_load, disp_exp;

  assign any_press    = (press != '0);
  assign single_press = is_one_hot(8'(press));

  always_comb begin
    state_d      = state_q;
    vote_valid_d = '0;
    timeout_d    = 1'b0;
    disp_sel_d   = disp_sel_q;
    spoil_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Stray presses while nobody is armed are spoiled, even if mode is up.
        if (!enable_ballot && any_press) spoil_inc = 1'b1;
        if (mode) begin
          state_d = ST_COUNT;
        end else if (enable_ballot) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (mode) begin
          state_d = ST_COUNT;
        end else if (single_press) begin
          state_d      = ST_COMMIT;
          vote_valid_d = press;
        end else if (any_press) begin
          spoil_inc = 1'b1;
          state_d   = ST_IDLE;
        end else if (arm_exp) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_d = ST_LOCKOUT;
      end
      ST_LOCKOUT: begin
        if (any_press) spoil_inc = 1'b1;
        if (lock_exp) state_d = ST_IDLE;
      end
      ST_COUNT: begin
        if (!mode) begin
          state_d    = ST_IDLE;
          disp_sel_d = '0;
        end else if (disp_exp) begin
          disp_sel_d = (disp_sel_q == DW'(N_CAND - 1)) ? '0 : disp_sel_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    spoiled_d = spoiled_q;
    if (spoil_inc && (spoiled_q != SPOIL_SAT)) spoiled_d = spoiled_q + SPOIL_W'(1);

    ready_d = (state_d == ST_ARMED);
    ack_d   = (state_d == ST_LOCKOUT);
  end

  assign arm_load  = (state_d == ST_ARMED) && (state_q != ST_ARMED);
  assign lock_load = (state_q == ST_COMMIT);
  assign disp_load = (state_d == ST_COUNT) && ((state_q != ST_COUNT) || disp_exp);

  ballot_timer #(.W(TW)) u_arm_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (arm_load),
    .load_val (TW'(TIMEOUT_CYCLES)),
    .expired  (arm_exp)
  );

  ballot_timer #(.W(TW)) u_lock_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (lock_load),
    .load_val (TW'(ACK_CYCLES)),
    .expired  (lock_exp)
  );

  ballot_timer #(.W(TW)) u_disp_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (disp_load),
    .load_val (TW'(DISP_CYCLES)),
    .expired  (disp_exp)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      vote_valid_q <= '0;
      ready_q      <= 1'b0;
      ack_q        <= 1'b0;
      timeout_q    <= 1'b0;
      spoiled_q    <= '0;
      disp_sel_q   <= '0;
    end else begin
      state_q      <= state_d;
      vote_valid_q <= vote_valid_d;
      ready_q      <= ready_d;
      ack_q        <= ack_d;
      timeout_q    <= timeout_d;
      spoiled_q    <= spoiled_d;
      disp_sel_q   <= disp_sel_d;
    end
  end

  assign vote_valid  = vote_valid_q;
  assign ready       = ready_q;
  assign ack         = ack_q;
  assign timeout     = timeout_q;
  assign spoiled_cnt = spoiled_q;
  assign disp_sel    = disp_sel_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed scenarios plus a randomized run against a phase/age reference model.
module tb_ballot_controller;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int AK = 4;
  localparam int DS = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         mode;
  logic         enable_ballot;
  logic [N-1:0] press;
  logic [N-1:0] vote_valid;
  logic         ready;
  logic         ack;
  logic         timeout;
  logic [7:0]   spoiled_cnt;
  logic [1:0]   disp_sel;

  int total = 0;
  int bad   = 0;

  // Reference model: a named phase, cycles spent in it, and plain counters.
  string        m_phase;
  int           m_age;
  int           m_spoil;
  int           m_disp;
  logic [N-1:0] m_vv;
  logic         m_to;

  ballot_controller #(
    .N_CAND         (N),
    .TIMEOUT_CYCLES (TO),
    .ACK_CYCLES     (AK),
    .DISP_CYCLES    (DS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mode          (mode),
    .enable_ballot (enable_ballot),
    .press         (press),
    .vote_valid    (vote_valid),
    .ready         (ready),
    .ack           (ack),
    .timeout       (timeout),
    .spoiled_cnt   (spoiled_cnt),
    .disp_sel      (disp_sel)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_phase = "idle";
    m_age   = 0;
    m_spoil = 0;
    m_disp  = 0;
    m_vv    = '0;
    m_to    = 1'b0;
  endfunction

  function automatic void bump();
    if (m_spoil < 255) m_spoil++;
  endfunction

  function automatic void model_step(input logic m, input logic e, input logic [N-1:0] p);
    m_vv = '0;
    m_to = 1'b0;
    if (m_phase == "idle") begin
      if (!e && p != 0) bump();
      if (m) begin
        m_phase = "count"; m_age = 0; m_disp = 0;
      end else if (e) begin
        m_phase = "armed"; m_age = 0;
      end
    end else if (m_phase == "armed") begin
      m_age++;
      if (m) begin
        m_phase = "count"; m_age = 0;
      end else if ($countones(p) == 1) begin
        m_vv = p; m_phase = "commit";
      end else if (p != 0) begin
        bump(); m_phase = "idle";
      end else if (m_age == TO) begin
        m_to = 1'b1; m_phase = "idle";
      end
    end else if (m_phase == "commit") begin
      m_phase = "lock"; m_age = 0;
    end else if (m_phase == "lock") begin
      m_age++;
      if (p != 0) bump();
      if (m_age == AK) m_phase = "idle";
    end else begin
      if (!m) begin
        m_phase = "idle"; m_disp = 0;
      end else begin
        m_age++;
        if (m_age == DS) begin
          m_age = 0; m_disp = (m_disp + 1) % N;
        end
      end
    end
  endfunction

  task automatic drive(input logic m, input logic e, input logic [N-1:0] p);
    mode = m; enable_ballot = e; press = p;
    if (!reset) model_reset();
    else model_step(m, e, p);
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'($urandom), 1'($urandom), 4'($urandom));
    drive(1'($urandom), 1'($urandom), 4'($urandom));
    total++; if (vote_valid !== 4'd0) begin bad++; $display("FAIL reset_vote_valid got=%h want=0", vote_valid); end
    total++; if (ready !== 1'b0)       begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (ack !== 1'b0)         begin bad++; $display("FAIL reset_ack got=%b want=0", ack); end
    total++; if (timeout !== 1'b0)     begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    total++; if (spoiled_cnt !== 8'd0) begin bad++; $display("FAIL reset_spoiled got=%0d want=0", spoiled_cnt); end
    total++; if (disp_sel !== 2'd0)    begin bad++; $display("FAIL reset_disp got=%0d want=0", disp_sel); end
    reset = 1'b1;
    drive(1'b0, 1'b1, '0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_then_arm ready got=%b want=1", ready); end
  endtask

  task automatic test_vote();
    int  acks;
    bit  side_bad;
    apply_reset();
    drive(1'b0, 1'b1, '0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL vote_armed ready got=%b want=1", ready); end
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 4'b0100);
    total++; if (vote_valid !== 4'b0100) begin bad++; $display("FAIL vote_commit got=%b want=0100", vote_valid); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL vote_ready_drop got=%b want=0", ready); end
    drive(1'b0, 1'b0, '0);
    total++; if (vote_valid !== 4'b0000) begin bad++; $display("FAIL vote_one_cycle got=%b want=0000", vote_valid); end
    acks = (ack === 1'b1) ? 1 : 0;
    side_bad = 1'b0;
    for (int i = 0; i < 12 && ack === 1'b1; i++) begin
      drive(1'b0, 1'b0, '0);
      if (ack === 1'b1) acks++;
      if (ready !== 1'b0 || vote_valid !== 4'b0000) side_bad = 1'b1;
    end
    total++; if (acks != AK) begin bad++; $display("FAIL vote_ack_len got=%0d want=%0d", acks, AK); end
    total++; if (side_bad) begin bad++; $display("FAIL vote_quiet_lockout got=1 want=0"); end
  endtask

  task automatic test_spoil();
    apply_reset();
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 4'b0011);
    total++; if (vote_valid !== 4'b0000) begin bad++; $display("FAIL spoil_no_vote got=%b want=0000", vote_valid); end
    total++; if (spoiled_cnt !== 8'd1) begin bad++; $display("FAIL spoil_count got=%0d want=1", spoiled_cnt); end
    drive(1'b0, 1'b0, '0);
    total++; if (ready !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL spoil_idle ready=%b ack=%b want=0,0", ready, ack); end
  endtask

  task automatic test_timeout();
    int k;
    bit seen;
    apply_reset();
    drive(1'b0, 1'b1, '0);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      drive(1'b0, 1'b0, '0);
      k++;
      if (timeout === 1'b1) seen = 1'b1;
    end
    total++; if (!seen || k != TO) begin bad++; $display("FAIL timeout_delay got=%0d seen=%0d want=%0d", k, seen, TO); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL timeout_ready got=%b want=0", ready); end
    drive(1'b0, 1'b0, '0);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_pulse_width got=%b want=0", timeout); end
  endtask

  task automatic test_lockout_spoil();
    apply_reset();
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 4'b0001);
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'b1000);
    total++; if (spoiled_cnt !== 8'd3) begin bad++; $display("FAIL lockout_spoil got=%0d want=3", spoiled_cnt); end
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL lockout_ack got=%b want=1", ack); end
    drive(1'b0, 1'b0, '0);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL lockout_end got=%b want=0", ack); end
    drive(1'b0, 1'b0, 4'b0010);
    total++; if (spoiled_cnt !== 8'd4) begin bad++; $display("FAIL idle_spoil got=%0d want=4", spoiled_cnt); end
    for (int i = 0; i < 250; i++) drive(1'b0, 1'b0, 4'b0001);
    total++; if (spoiled_cnt !== 8'd254) begin bad++; $display("FAIL spoil_254 got=%0d want=254", spoiled_cnt); end
    for (int i = 0; i < 50; i++) drive(1'b0, 1'b0, 4'b0001);
    total++; if (spoiled_cnt !== 8'd255) begin bad++; $display("FAIL spoil_saturate got=%0d want=255", spoiled_cnt); end
  endtask

  task automatic test_count();
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, '0);
      total++;
      if (disp_sel !== 2'((i / DS) % N)) begin
        bad++; $display("FAIL count_seq[%0d] got=%0d want=%0d", i, disp_sel, (i / DS) % N);
      end
    end
    drive(1'b1, 1'b0, 4'b1111);
    total++; if (spoiled_cnt !== 8'd0) begin bad++; $display("FAIL count_press_ignored got=%0d want=0", spoiled_cnt); end
    total++; if (disp_sel !== 2'd1) begin bad++; $display("FAIL count_adv got=%0d want=1", disp_sel); end
    drive(1'b0, 1'b0, '0);
    total++; if (disp_sel !== 2'd0) begin bad++; $display("FAIL count_exit_clear got=%0d want=0", disp_sel); end
    drive(1'b0, 1'b1, '0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL count_exit_idle ready=%b want=1", ready); end
    drive(1'b1, 1'b0, 4'b0100);
    total++; if (vote_valid !== 4'b0000 || ready !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL armed_abort vv=%b ready=%b to=%b want=0000,0,0", vote_valid, ready, timeout);
    end
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    total++; if (disp_sel !== 2'd0) begin bad++; $display("FAIL abort_dwell got=%0d want=0", disp_sel); end
    drive(1'b1, 1'b0, '0);
    total++; if (disp_sel !== 2'd1) begin bad++; $display("FAIL abort_count_step got=%0d want=1", disp_sel); end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    drive(1'b0, 1'b1, '0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'b0001);
    total++; if (vote_valid !== 4'b0000 || ready !== 1'b0) begin
      bad++; $display("FAIL reset_press vv=%b ready=%b want=0000,0", vote_valid, ready);
    end
    reset = 1'b1;
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 4'b1000);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    total++; if (vote_valid !== 4'b0000 || ack !== 1'b0) begin
      bad++; $display("FAIL reset_inflight vv=%b ack=%b want=0000,0", vote_valid, ack);
    end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    int           votes, arms;
    logic         prev_ready;
    logic [N-1:0] p;
    bit           wrong_vote;
    apply_reset();
    votes = 0; arms = 0; prev_ready = 1'b0; wrong_vote = 1'b0;
    for (int i = 0; i < 35; i++) begin
      p = (ready === 1'b1) ? 4'b0010 : 4'b0000;
      drive(1'b0, 1'b1, p);
      if (vote_valid !== 4'b0000) begin
        votes++;
        if (vote_valid !== 4'b0010) wrong_vote = 1'b1;
      end
      if (ready === 1'b1 && prev_ready !== 1'b1) arms++;
      prev_ready = ready;
    end
    total++; if (votes != 5) begin bad++; $display("FAIL b2b_votes got=%0d want=5", votes); end
    total++; if (arms != 5) begin bad++; $display("FAIL b2b_arms got=%0d want=5", arms); end
    total++; if (wrong_vote || spoiled_cnt !== 8'd0) begin
      bad++; $display("FAIL b2b_clean wrong=%0d spoiled=%0d want=0,0", wrong_vote, spoiled_cnt);
    end
  endtask

  task automatic test_random();
    logic         rm;
    logic         re;
    logic [N-1:0] rp;
    int           r;
    logic [16:0]  exp_v, act_v;
    apply_reset();
    rm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rm = ~rm;
      re = ($urandom_range(0, 2) == 0);
      r  = int'($urandom_range(0, 99));
      if (r < 55)      rp = '0;
      else if (r < 85) rp = 4'b0001 << $urandom_range(0, 3);
      else             rp = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      drive(rm, re, rp);
      exp_v = {m_vv, m_phase == "armed", m_phase == "lock", m_to, 8'(m_spoil), 2'(m_disp)};
      act_v = {vote_valid, ready, ack, timeout, spoiled_cnt, disp_sel};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL random[%0d] got=%h want=%h (vv,ready,ack,to,spoil,disp)", i, act_v, exp_v);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; mode = 1'b0; enable_ballot = 1'b0; press = '0;
    model_reset();
    test_reset();
    test_vote();
    test_spoil();
    test_timeout();
    test_lockout_spoil();
    test_count();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
